// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request; the slave (the subtractor) returns status and results.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             overflow;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, overflow
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, one full-subtractor bit per clock, LSB first.
// Results are held until the next operation completes or reset.
module serial_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                clk,
  input logic                reset,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;

  logic             a_bit, b_bit, d_bit, br_next;
  logic [WIDTH-1:0] res_shift;

  // Single full-subtractor cell operating on the current LSBs.
  assign a_bit     = a_sh_q[0];
  assign b_bit     = b_sh_q[0];
  assign d_bit     = a_bit ^ b_bit ^ br_q;
  assign br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  assign res_shift = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    diff_d  = diff_q;
    b_out_d = b_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          br_d    = bus.b_in;
          a_msb_d = bus.a[WIDTH-1];
          b_msb_d = bus.b[WIDTH-1];
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        res_d  = res_shift;
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          // d_bit is the result MSB on the final bit.
          diff_d  = res_shift;
          b_out_d = br_next;
          ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      diff_q  <= '0;
      b_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      diff_q  <= diff_d;
      b_out_q <= b_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy     = (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.diff     = diff_q;
  assign bus.b_out    = b_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results are queued on each accepted
// start and compared against the outputs on every done pulse.
module tb_serial_subtractor;
  localparam int unsigned WIDTH = 4;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;
  } res_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(WIDTH)) sif ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    logic [WIDTH:0] full;
    res_t r;
    full    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    r.diff  = full[WIDTH-1:0];
    r.b_out = full[WIDTH];
    r.ovf   = (a[WIDTH-1] ^ b[WIDTH-1]) & (full[WIDTH-1] ^ a[WIDTH-1]);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    res_t r;
    if (!reset && sif.done) begin
      check("busy_with_done", {31'b0, sif.busy}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", exp_q.size(), 32'd1);
      end else begin
        r = exp_q.pop_front();
        check("result", {26'b0, sif.diff, sif.b_out, sif.overflow}, {26'b0, r});
      end
    end
  end

  // Drive one request, wait for acceptance, then check latency, busy length and stability.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    int k;
    int busy_n;
    logic [WIDTH+1:0] held;
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = a;
    sif.b     = b;
    sif.b_in  = bin;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!sif.busy && k < 4);
    check("accept", {31'b0, sif.busy}, 32'd1);
    sif.start = 1'b0;
    exp_q.push_back(model(a, b, bin));
    held   = {sif.diff, sif.b_out, sif.overflow};
    busy_n = 0;
    k      = 0;
    while (k < WIDTH + 3) begin
      @(negedge clk);
      k++;
      if (sif.done) break;
      if (sif.busy) begin
        busy_n++;
        check("stable_in_run", {26'b0, sif.diff, sif.b_out, sif.overflow}, {26'b0, held});
      end
    end
    check("latency", k, WIDTH + 1);
    check("busy_cycles", busy_n, WIDTH);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (k < WIDTH + 3) begin
      @(negedge clk);
      k++;
      if (sif.done) break;
    end
    check(tag, {31'b0, sif.done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sif.start = 1'b0;
    sif.a     = '0;
    sif.b     = '0;
    sif.b_in  = 1'b0;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'b0, sif.busy}, 32'd0);
    check("rst_done", {31'b0, sif.done}, 32'd0);
    check("rst_diff", {28'b0, sif.diff}, 32'd0);
    check("rst_b_out", {31'b0, sif.b_out}, 32'd0);
    check("rst_ovf", {31'b0, sif.overflow}, 32'd0);
    reset = 1'b0;

    run_op(4'd7, 4'd3, 1'b0);

    // Abort mid-run: reset asserted in the second RUN cycle.
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 4'd9;
    sif.b     = 4'd2;
    sif.b_in  = 1'b0;
    @(posedge clk);
    #1;
    check("abort_accept", {31'b0, sif.busy}, 32'd1);
    sif.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'b0, sif.busy}, 32'd0);
    check("abort_done", {31'b0, sif.done}, 32'd0);
    check("abort_diff", {28'b0, sif.diff}, 32'd0);
    check("abort_b_out", {31'b0, sif.b_out}, 32'd0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_pending", exp_q.size(), 32'd0);
    run_op(4'd5, 4'd2, 1'b0);

    run_op(4'd3, 4'd7, 1'b0);
    run_op(4'd0, 4'd0, 1'b1);
    run_op(4'd15, 4'd15, 1'b0);
    run_op(4'd8, 4'd1, 1'b0);
    run_op(4'd7, 4'd15, 1'b0);

    // Start re-asserted during RUN is ignored, then accepted in the IDLE cycle after DONE.
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 4'd7;
    sif.b     = 4'd3;
    sif.b_in  = 1'b0;
    @(posedge clk);
    #1;
    check("ign_accept", {31'b0, sif.busy}, 32'd1);
    sif.start = 1'b0;
    exp_q.push_back(model(4'd7, 4'd3, 1'b0));
    @(negedge clk);
    @(negedge clk);
    sif.start = 1'b1;
    sif.a     = 4'd1;
    sif.b     = 4'd1;
    wait_done("ign_done");
    exp_q.push_back(model(4'd1, 4'd1, 1'b0));
    @(posedge clk);
    #1;
    check("restart_idle", {31'b0, sif.busy}, 32'd0);
    @(posedge clk);
    #1;
    check("restart_accept", {31'b0, sif.busy}, 32'd1);
    sif.start = 1'b0;
    wait_done("restart_done");

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          run_op(4'(ia), 4'(ib), 1'(ic));
        end
      end
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
